// File: rtl/scan_enc_pkg.sv
// Shared constants and state type for the scanning 8-to-3 priority encoder.
//   N_IN    : request vector width (fixed at 8)
//   IDX_W   : index width, $clog2(N_IN)
//   state_t : scanner FSM state {IDLE, SCAN}
package scan_enc_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational lowest-set-bit encoder.
//   vec     in  [N_IN-1:0]   vector to encode
//   idx     out [IDX_W-1:0]  index of the lowest set bit (0 when vec is zero)
//   any     out              vec has at least one bit set
//   one_hot out              vec has exactly one bit set
module priority_encoder_8to3
    import scan_enc_pkg::*;
(
    input  logic [N_IN-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one_hot
);

    always_comb begin
        idx = '0;
        // Walk from the top down so the lowest set bit is the last one written.
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx = IDX_W'(k);
            end
        end
        any     = |vec;
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        one_hot = any && ((vec & (vec - 1'b1)) == '0);
    end

endmodule

// File: rtl/scan_priority_encoder_8to3.sv
// Scanning priority encoder: accepts an 8-bit request vector and emits the index
// of every set bit, lowest first, one per accepted output beat.
//   clk        in        rising-edge clock
//   rst_n      in        synchronous reset, active-low
//   in_valid   in        in_vec valid
//   in_ready   out       block can accept a vector (IDLE and not in reset)
//   in_vec     in  [7:0] request vector
//   out_valid  out       out_idx/out_last valid
//   out_ready  in        consumer takes the beat
//   out_idx    out [2:0] index of the lowest still-pending bit
//   out_last   out       final index of the current vector
//   busy       out       scan in progress
//   out_zero   out       (only with SCAN_ENC_ZERO_BEAT_EN) beat stands for an all-zero vector
// Build option: define SCAN_ENC_ZERO_BEAT_EN to turn an all-zero vector into a
// single idx=0 beat flagged by out_zero; otherwise all-zero vectors are dropped.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// SCAN  | presenting lowest pending index from pend, in_ready=0
module scan_priority_encoder_8to3
    import scan_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
`ifdef SCAN_ENC_ZERO_BEAT_EN
    output logic             out_zero,
`endif
    output logic             busy
);

    state_t           state;
    logic [N_IN-1:0]  pend;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_one_hot;

    priority_encoder_8to3 u_enc (
        .vec     (pend),
        .idx     (enc_idx),
        .any     (enc_any),
        .one_hot (enc_one_hot)
    );

    // Everything downstream comes from state/pend registers, so in_vec
    // activity during a scan cannot reach the output.
    assign busy      = (state == SCAN);
    assign out_valid = busy;
    assign out_idx   = enc_idx;
    // An empty pend while scanning can only be the zero-vector beat, which is
    // also the last one.
    assign out_last  = busy && (enc_one_hot || !enc_any);
    assign in_ready  = rst_n && (state == IDLE);

`ifdef SCAN_ENC_ZERO_BEAT_EN
    assign out_zero  = busy && !enc_any;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pend <= in_vec;
`ifdef SCAN_ENC_ZERO_BEAT_EN
                        state <= SCAN;
`else
                        if (in_vec != '0) begin
                            state <= SCAN;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        pend <= pend & ~(N_IN'(1) << enc_idx);
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
